// File: rtl/sys_int_mem_pipelined.sv
// sys_int_mem_pipelined: on-chip scratch RAM behind an Avalon-MM slave.
//   Parameters: DATA_WIDTH (multiple of 8), ADDR_WIDTH, DEPTH (<= 2**ADDR_WIDTH),
//   READ_LATENCY (1 or 2), INIT_CLEAR (1 = zero-clear sweep after reset).
//   Optional build macro: SYS_INT_MEM_PARITY_EN adds per-byte even parity and
//   the sticky parity_error output.
// Ports:
//   clk, reset (async, active-high)
//   address/byteenable/chipselect/read/write/writedata : Avalon-MM request
//   clken      : global enable, 0 stalls everything including the read pipe
//   freeze, reset_req : block acceptance of new transfers
//   readdata/readdatavalid : read response, readdata is 0 when not valid
//   waitrequest: combinational back-pressure
//   init_done  : high once the clear sweep has completed
//   parity_error (optional): sticky per-byte parity mismatch on read data
module sys_int_mem_pipelined #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 13,
  parameter int unsigned DEPTH        = 8192,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned INIT_CLEAR   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [DATA_WIDTH/8-1:0]   byteenable,
  input  logic                      chipselect,
  input  logic                      read,
  input  logic                      write,
  input  logic [DATA_WIDTH-1:0]     writedata,
  input  logic                      clken,
  input  logic                      freeze,
  input  logic                      reset_req,
  output logic [DATA_WIDTH-1:0]     readdata,
  output logic                      readdatavalid,
  output logic                      waitrequest,
  output logic                      init_done
`ifdef SYS_INT_MEM_PARITY_EN
  ,
  output logic                      parity_error
`endif
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   sweep_q, sweep_d;
  logic               sweep_we;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic               in_range;
  logic [IDX_W-1:0]   idx;
  logic               accept;
  logic               wr_acc;
  logic               rd_acc;
  logic [DATA_WIDTH-1:0] rd_word;

  // Request decode
  assign waitrequest = (state_q != ST_RUN) | ~clken | freeze | reset_req;
  assign in_range    = {1'b0, address} < (ADDR_WIDTH + 1)'(DEPTH);
  assign idx         = address[IDX_W-1:0];
  assign accept      = chipselect & (read | write) & ~waitrequest;
  assign wr_acc      = accept & write & in_range;
  // A combined read+write performs only the write
  assign rd_acc      = accept & read & ~write;
  assign rd_word     = in_range ? mem[idx] : '0;

  // State and sweep counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
      sweep_q   <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      sweep_q   <= sweep_d;
      init_done <= (state_d == ST_RUN);
    end
  end

  // Next-state: sweep one word per enabled clock, then run
  always_comb begin
    state_d  = state_q;
    sweep_d  = sweep_q;
    sweep_we = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (clken) begin
          sweep_we = 1'b1;
          if (sweep_q == IDX_W'(DEPTH - 1)) begin
            state_d = ST_RUN;
            sweep_d = '0;
          end else begin
            sweep_d = sweep_q + IDX_W'(1);
          end
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Storage array: sweep and bus writes are mutually exclusive (waitrequest)
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_q] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (byteenable[b]) mem[idx][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

  // Read pipeline; data is zeroed whenever the slot is not a valid read
  logic [READ_LATENCY-1:0] pv;
  logic [DATA_WIDTH-1:0]   pd [READ_LATENCY];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pd[i] <= '0;
    end else if (clken) begin
      pv[0] <= rd_acc;
      pd[0] <= rd_acc ? rd_word : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign readdatavalid = pv[READ_LATENCY-1];
  assign readdata      = pd[READ_LATENCY-1];

`ifdef SYS_INT_MEM_PARITY_EN
  logic [NB-1:0] par [DEPTH];
  logic [NB-1:0] rd_par;
  logic [NB-1:0] pp [READ_LATENCY];
  logic          fin_v;
  logic [DATA_WIDTH-1:0] fin_d;
  logic [NB-1:0] fin_p;
  logic [NB-1:0] mm;

  // Parity storage follows the data array; zero words have even parity 0
  always_ff @(posedge clk) begin
    if (sweep_we) begin
      par[sweep_q] <= '0;
    end else if (wr_acc) begin
      for (int b = 0; b < NB; b++) begin
        if (byteenable[b]) par[idx][b] <= ^writedata[8*b +: 8];
      end
    end
  end

  assign rd_par = in_range ? par[idx] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) pp[i] <= '0;
    end else if (clken) begin
      pp[0] <= rd_acc ? rd_par : '0;
      for (int i = 1; i < READ_LATENCY; i++) pp[i] <= pp[i-1];
    end
  end

  // Word entering the output stage: checked on the edge it becomes readdata
  generate
    if (READ_LATENCY == 1) begin : g_fin1
      assign fin_v = rd_acc;
      assign fin_d = rd_acc ? rd_word : '0;
      assign fin_p = rd_acc ? rd_par : '0;
    end else begin : g_fin2
      assign fin_v = pv[READ_LATENCY-2];
      assign fin_d = pd[READ_LATENCY-2];
      assign fin_p = pp[READ_LATENCY-2];
    end
  endgenerate

  always_comb begin
    mm = '0;
    for (int b = 0; b < NB; b++) mm[b] = (^fin_d[8*b +: 8]) ^ fin_p[b];
  end

  // Sticky until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_error <= 1'b0;
    else if (clken && fin_v && (|mm)) parity_error <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_sys_int_mem_pipelined.sv
// Bench for sys_int_mem_pipelined: two instances (read latency 1 and 2) share
// stimulus and are checked every cycle against a transaction-level model.
module tb_sys_int_mem_pipelined;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  address = '0;
  logic [7:0]  byteenable = '0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [63:0] writedata = '0;
  logic        clken = 1'b1;
  logic        freeze = 1'b0;
  logic        reset_req = 1'b0;

  logic [63:0] rd1, rd2;
  logic        rdv1, rdv2, wr1, wr2, id1, id2;
  logic        pe1, pe2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sys_int_mem_pipelined #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .DEPTH(16),
                          .READ_LATENCY(1), .INIT_CLEAR(1)) dut1 (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .freeze(freeze), .reset_req(reset_req),
    .readdata(rd1), .readdatavalid(rdv1), .waitrequest(wr1), .init_done(id1)
`ifdef SYS_INT_MEM_PARITY_EN
    , .parity_error(pe1)
`endif
  );

  sys_int_mem_pipelined #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .DEPTH(16),
                          .READ_LATENCY(2), .INIT_CLEAR(1)) dut2 (
    .clk(clk), .reset(reset), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .freeze(freeze), .reset_req(reset_req),
    .readdata(rd2), .readdatavalid(rdv2), .waitrequest(wr2), .init_done(id2)
`ifdef SYS_INT_MEM_PARITY_EN
    , .parity_error(pe2)
`endif
  );

`ifndef SYS_INT_MEM_PARITY_EN
  assign pe1 = 1'b0;
  assign pe2 = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed { logic v; logic [63:0] d; logic bad; } ent_t;

  logic [63:0] m [16];
  logic [7:0]  bad [16];
  ent_t        h0, h1;     // read results of the last and second-to-last enabled edges
  ent_t        nx;
  logic        run, acc, pe1_e, pe2_e, ce_last;
  int          cnt;
  int          flip_seq = 0, flip_seen = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      run = 1'b0; cnt = 0; h0 = '0; h1 = '0;
      pe1_e = 1'b0; pe2_e = 1'b0; ce_last = 1'b0;
      for (int i = 0; i < 16; i++) begin m[i] = '0; bad[i] = '0; end
    end else begin
      if (flip_seen != flip_seq) begin
        flip_seen = flip_seq;
        m[2][0] = ~m[2][0];
        bad[2][0] = 1'b1;
      end
      ce_last = clken;
      if (clken) begin
        nx  = '0;
        acc = chipselect && (read || write) && run && !freeze && !reset_req;
        if (acc && read && !write) begin
          nx.v = 1'b1;
          if (address < 5'd16) begin
            nx.d   = m[address[3:0]];
            nx.bad = |bad[address[3:0]];
          end
        end
        if (acc && write && address < 5'd16)
          for (int b = 0; b < 8; b++)
            if (byteenable[b]) begin
              m[address[3:0]][8*b +: 8] = writedata[8*b +: 8];
              bad[address[3:0]][b] = 1'b0;
            end
        if (!run) begin
          cnt++;
          if (cnt == 16) run = 1'b1;
        end
        h1 = h0;
        h0 = nx;
`ifdef SYS_INT_MEM_PARITY_EN
        pe1_e = pe1_e | (h0.v & h0.bad);
        pe2_e = pe2_e | (h1.v & h1.bad);
`endif
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [63:0] last_rd1 = '0, last_rd2 = '0;
  int          rdv1_cnt = 0;
  logic [63:0] q1 [$];

  always @(negedge clk) begin
    chk("waitrequest_l1", 64'(wr1), 64'(!run || !clken || freeze || reset_req));
    chk("waitrequest_l2", 64'(wr2), 64'(!run || !clken || freeze || reset_req));
    chk("init_done_l1", 64'(id1), 64'(run));
    chk("init_done_l2", 64'(id2), 64'(run));
    chk("readdatavalid_l1", 64'(rdv1), 64'(h0.v));
    chk("readdata_l1", rd1, h0.d);
    chk("readdatavalid_l2", 64'(rdv2), 64'(h1.v));
    chk("readdata_l2", rd2, h1.d);
    chk("parity_error_l1", 64'(pe1), 64'(pe1_e));
    chk("parity_error_l2", 64'(pe2), 64'(pe2_e));
    if (rdv1 && ce_last) begin
      last_rd1 = rd1;
      rdv1_cnt++;
      q1.push_back(rd1);
    end
    if (rdv2 && ce_last) last_rd2 = rd2;
  end

  // ---------------- stimulus ----------------
  task automatic op(input logic r, input logic w, input logic [4:0] a,
                    input logic [63:0] d, input logic [7:0] be);
    chipselect = 1'b1; read = r; write = w; address = a; writedata = d; byteenable = be;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!id1 && n < 100) begin @(posedge clk); n++; #1; end
  endtask

  int n, c0;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Sweep with a 3-cycle clken stall: 16 enabled edges, 19 edges total
    n = 0;
    repeat (5) begin @(posedge clk); n++; end
    #1 clken = 1'b0;
    repeat (3) begin @(posedge clk); n++; end
    #1 clken = 1'b1;
    while (!id1 && n < 100) begin @(posedge clk); n++; #1; end
    chk("sweep_edges", 64'(n), 64'd19);

    op(1, 0, 5'd5, '0, '0); idle(3);
    chk("read_after_clear", last_rd1, 64'h0);

    // Byte-lane merge
    op(0, 1, 5'd3, 64'h1122334455667788, 8'hFF);
    op(0, 1, 5'd3, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    op(1, 0, 5'd3, '0, '0); idle(3);
    chk("byte_merge_l1", last_rd1, 64'h11223344AAAAAAAA);
    chk("byte_merge_l2", last_rd2, 64'h11223344AAAAAAAA);
    chk("model_mem3", m[3], 64'h11223344AAAAAAAA);

    // Back-to-back burst with a mid-burst clken stall
    for (int i = 0; i < 4; i++) op(0, 1, 5'(i), 64'h10 + 64'(i), 8'hFF);
    q1.delete();
    op(1, 0, 5'd0, '0, '0);
    op(1, 0, 5'd1, '0, '0);
    clken = 1'b0;
    op(1, 0, 5'd2, '0, '0);
    op(1, 0, 5'd2, '0, '0);
    op(1, 0, 5'd2, '0, '0);
    clken = 1'b1;
    op(1, 0, 5'd2, '0, '0);
    op(1, 0, 5'd3, '0, '0);
    idle(3);
    chk("burst_count", 64'(q1.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("burst_data", (i < q1.size()) ? q1[i] : '1, 64'h10 + 64'(i));

    // Freeze/reset_req after an accepted read: read completes, writes blocked
    op(1, 0, 5'd1, '0, '0);
    freeze = 1'b1;
    op(0, 1, 5'd1, 64'hDEAD, 8'hFF);
    op(0, 1, 5'd1, 64'hDEAD, 8'hFF);
    freeze = 1'b0;
    chk("inflight_read_l2", last_rd2, 64'h11);
    reset_req = 1'b1;
    op(0, 1, 5'd1, 64'hBEEF, 8'hFF);
    reset_req = 1'b0;
    idle(2);
    op(1, 0, 5'd1, '0, '0); idle(3);
    chk("freeze_write_blocked", last_rd1, 64'h11);

    // Simultaneous read+write: write only
    c0 = rdv1_cnt;
    op(1, 1, 5'd7, 64'h5A, 8'hFF); idle(3);
    chk("rw_no_valid", 64'(rdv1_cnt - c0), 64'd0);
    op(1, 0, 5'd7, '0, '0); idle(3);
    chk("rw_write_done_l1", last_rd1, 64'h5A);
    chk("rw_write_done_l2", last_rd2, 64'h5A);

    // Out of range: write discarded, read returns zero with a valid pulse
    op(0, 1, 5'd16, 64'hFFFF, 8'hFF);
    c0 = rdv1_cnt;
    op(1, 0, 5'd16, '0, '0); idle(3);
    chk("oor_valid", 64'(rdv1_cnt - c0), 64'd1);
    chk("oor_data", last_rd1, 64'h0);

`ifdef SYS_INT_MEM_PARITY_EN
    // Backdoor corruption of a stored bit
    dut1.mem[2][0] = ~dut1.mem[2][0];
    dut2.mem[2][0] = ~dut2.mem[2][0];
    flip_seq++;
    idle(1);
    op(1, 0, 5'd2, '0, '0); idle(3);
    chk("parity_set", 64'(pe1), 64'd1);
    chk("parity_data_unmodified", last_rd1, 64'h13);
    op(1, 0, 5'd0, '0, '0); idle(3);
    chk("parity_sticky_l1", 64'(pe1), 64'd1);
    chk("parity_sticky_l2", 64'(pe2), 64'd1);
`endif

    // Reset mid-run restarts the sweep and clears everything
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    wait_init(n);
    chk("resweep_edges", 64'(n), 64'd16);
    op(1, 0, 5'd3, '0, '0); idle(3);
    chk("resweep_cleared", last_rd1, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sys_int_mem_pipelined.md
Name: sys_int_mem_pipelined

Overview:
Parametrised on-chip RAM with an Avalon-MM slave. Successor to the single-port internal memory: configurable width and depth, pipelined reads with readdatavalid, and a waitrequest-based back-pressure. Also adds a post-reset zero-clear sweep and a freeze/reset_req quiesce. Sits on the HPS/fabric interconnect as the system scratch memory.

Parameters:
DATA_WIDTH, 64, data bus width in bits; must be a multiple of 8.
ADDR_WIDTH, 13, word address width.
DEPTH, 8192, number of words; must be <= 2**ADDR_WIDTH.
READ_LATENCY, 1, read latency in accepted-cycle units; legal values 1 or 2 (2 adds an output register).
INIT_CLEAR, 1, 1 = zero every word after reset before accepting traffic; 0 = no sweep, contents undefined.

Ports:
clk  in  1  single clock for all logic.
reset  in  1  asynchronous, active-high reset.
address  in  ADDR_WIDTH  word address.
byteenable  in  DATA_WIDTH/8  write byte lanes.
chipselect  in  1  slave select.
read  in  1  read request.
write  in  1  write request.
writedata  in  DATA_WIDTH  write data.
clken  in  1  global clock enable; 0 stalls the entire block.
freeze  in  1  quiesce request; no new transfers accepted.
reset_req  in  1  reset pending; treated identically to freeze.
readdata  out  DATA_WIDTH  read data, valid only with readdatavalid.
readdatavalid  out  1  one-cycle strobe per accepted read.
waitrequest  out  1  1 = request not accepted this cycle.
init_done  out  1  1 once the clear sweep has finished (or immediately if INIT_CLEAR=0).
parity_error  out  1  present only with the optional feature.

Behaviour:
- Reset values: readdata=0, readdatavalid=0, waitrequest=1, init_done=0, parity_error=0. The read pipeline is flushed on reset.
- FSM states: INIT, RUN.
  - Reset enters INIT if INIT_CLEAR=1, otherwise RUN.
  - INIT writes zero to address 0..DEPTH-1, one word per clk with clken=1. The sweep counter holds while clken=0.
  - After address DEPTH-1 is written, the FSM moves to RUN on the next edge and init_done=1 from that edge.
  - Reset during INIT restarts the sweep from 0.
- waitrequest = (state!=RUN) | ~clken | freeze | reset_req. It is combinational from these inputs.
- Accept condition: chipselect & (read|write) & ~waitrequest.
- Write: accepted write updates the selected byte lanes at the edge. Lanes with byteenable=0 keep their old value.
- Read: an accepted read raises readdatavalid after exactly READ_LATENCY clken=1 edges, for one cycle.
  - Back-to-back reads give one result per cycle, in order.
  - clken=0 freezes the pipeline: readdatavalid and readdata hold their values.
- Read after write to the same address in the next cycle returns the new data (write-first ordering across cycles).
- Simultaneous read and write: the write is performed, the read is ignored, and no readdatavalid is generated.
- Address >= DEPTH: the write is discarded; the read returns all-zeros with the normal readdatavalid timing.
- freeze/reset_req asserted with reads in flight: in-flight reads still complete and deliver readdatavalid. Only new acceptance is blocked.
- readdata is 0 in any cycle where readdatavalid=0.

Optional Feature:
SYS_INT_MEM_PARITY_EN
- Defined: one even-parity bit is stored per byte, computed on write. The INIT sweep writes correct parity.
  - On each readdatavalid, any byte parity mismatch sets parity_error (sticky). It clears only on reset.
  - readdata is returned unmodified.
- Undefined: no parity storage, and the parity_error port is absent.

Test Plan:
- Reset release, INIT_CLEAR=1, DEPTH=16 -> waitrequest=1 for 16 clken cycles, then init_done=1; read of addr 5 returns 0.
- Write 0x1122334455667788 to addr 3 with byteenable=0xFF, then write 0xAAAAAAAAAAAAAAAA with byteenable=0x0F, then read addr 3 -> 0x11223344AAAAAAAA, readdatavalid at edge+READ_LATENCY for both latency values.
- Four back-to-back reads of addrs 0-3 pre-loaded with 0x10..0x13 -> four consecutive readdatavalid pulses returning 0x10,0x11,0x12,0x13. Hold clken=0 for 3 cycles mid-burst -> outputs hold, no extra or lost pulse.
- Assert freeze one cycle after a read is accepted -> waitrequest=1, the read still completes; write during freeze is not accepted and memory is unchanged.
- read=write=1 at addr 7 with writedata 0x5A -> no readdatavalid; a subsequent read returns 0x5A. Read of address DEPTH -> 0 with readdatavalid.
- SYS_INT_MEM_PARITY_EN: force-flip a stored bit via backdoor, then read -> parity_error=1 and stays 1 after further clean reads until reset.
